// File: rtl/booth_pkg.sv
// booth_pkg: shared types and sizing helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [2:0] booth_digit_t;
  localparam int WIDTH_DEF = 8;
  localparam int N_TRIP = WIDTH_DEF / 2;
  localparam int CNT_W = $clog2(N_TRIP);
  function automatic int n_trip(int w);
    return w / 2;
  endfunction
  function automatic int cnt_w(int w);
    return $clog2(w / 2);
  endfunction
endpackage

// File: rtl/booth_seq_mult_if.sv
// booth_seq_mult_if: operand and product valid/ready handshakes of the Booth multiplier.
interface booth_seq_mult_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [2*WIDTH-1:0] product;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: radix-4 Booth partial product and correction bit for one triplet.
// APPROX_CORR_EN selects the approximate correction bit instead of exact negation.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  booth_digit_t       trip,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] pp,
  output logic               corr
);
  logic [WIDTH:0] ae, mag, m;
  assign ae = {a[WIDTH-1], a};
  assign mag = (trip == 3'b011 || trip == 3'b100) ? {a, 1'b0} :
               (trip == 3'b000 || trip == 3'b111) ? '0 : ae;
  assign m = trip[2] ? ~mag : mag;
  assign pp = {{(WIDTH-1){m[WIDTH]}}, m};
`ifdef APPROX_CORR_EN
  // drops the +1 for -a with odd a and for the 111 digit
  assign corr = trip[2] & (~(trip[0] | trip[1]) | ~(a[0] | trip[1]) | ~(a[0] | trip[0]));
`else
  assign corr = trip[2];
`endif
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-4 Booth multiplier, one triplet per clock.
// Define APPROX_CORR_EN for the approximate correction-bit variant.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  booth_seq_mult_if.slave s
);
  localparam int NT = n_trip(WIDTH);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0] bx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, pp, ppc;
  logic corr;
  booth_digit_t trip;
  assign bx = {b_r, 1'b0};
  assign trip = bx[{cnt, 1'b0} +: 3];
  booth_pp_gen #(.WIDTH(WIDTH)) u_pp (.trip(trip), .a(a_r), .pp(pp), .corr(corr));
  assign ppc = pp + {{(2*WIDTH-1){1'b0}}, corr};
  assign s.in_ready = state == IDLE;
  assign s.busy = state == RUN;
  assign s.out_valid = state == DONE;
  assign s.product = acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      case (state)
        IDLE: if (s.in_valid) begin
          a_r <= s.a;
          b_r <= s.b;
          acc <= '0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          acc <= acc + (ppc << {cnt, 1'b0});
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NT - 1)) state <= DONE;
        end
        DONE: if (s.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: randomized self-checking bench for booth_seq_mult (WIDTH=8).
module tb_booth_seq_mult;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  booth_seq_mult_if #(.WIDTH(8)) bus ();
  booth_seq_mult #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // exact product, minus 4^i wherever the approximate correction drops the +1
  function automatic logic [15:0] ref_mul(input logic signed [7:0] x, input logic signed [7:0] y);
    int p;
    logic [8:0] be;
    logic [2:0] t;
    p = int'(x) * int'(y);
    be = {y, 1'b0};
`ifdef APPROX_CORR_EN
    for (int i = 0; i < 4; i++) begin
      t = be[2*i +: 3];
      if (t == 3'b111 || ((t == 3'b101 || t == 3'b110) && x[0])) p -= 4 ** i;
    end
`else
    t = be[2:0];
`endif
    return p[15:0];
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int hold,
                       output logic [15:0] p, output int lat);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.product;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
  endtask

  initial begin
    logic [15:0] p, hp, p1, p2;
    logic [7:0] x, y;
    int lat, seen;
    time t1, t2;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);

    do_op(8'd3, 8'd3, 0, p, lat);
    chk("lat_3x3", 32'(lat), 32'd4);
    chk("p_3x3", 32'(p), 32'(ref_mul(3, 3)));
    do_op(8'h80, 8'h80, 0, p, lat);
    chk("p_m128xm128", 32'(p), 32'(ref_mul(-128, -128)));
    do_op(8'd127, 8'h80, 0, p, lat);
    chk("p_127xm128", 32'(p), 32'(ref_mul(127, -128)));

    // consumer stall in DONE with a stray operand offer
    bus.a = 8'd7;
    bus.b = 8'(-9);
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    seen = 0;
    while (!bus.out_valid && seen < 50) begin
      @(posedge clk); #1;
      seen++;
    end
    hp = bus.product;
    chk("hold_value", 32'(hp), 32'(ref_mul(7, -9)));
    bus.in_valid = 1;
    bus.a = 8'd1;
    bus.b = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_product", 32'(bus.product), 32'(hp));
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_product", 32'(bus.product), 32'(hp));
    @(posedge clk); #1;
    chk("post_hs_busy", 32'(bus.busy), 32'd0);

    // abort in RUN at cnt=2
    bus.a = 8'd10;
    bus.b = 8'd11;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_run_busy", 32'(bus.busy), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_product", 32'(bus.product), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    do_op(8'd5, 8'(-7), 0, p, lat);
    chk("p_5xm7", 32'(p), 32'(ref_mul(5, -7)));

    // back-to-back with out_ready tied high
    bus.out_ready = 1;
    bus.a = 8'd2;
    bus.b = 8'd3;
    bus.in_valid = 1;
    @(posedge clk);
    t1 = $time;
    #1;
    bus.a = 8'(-4);
    bus.b = 8'd6;
    p1 = '0;
    seen = 0;
    while (!bus.in_ready && seen < 50) begin
      if (bus.out_valid) p1 = bus.product;
      @(posedge clk); #1;
      seen++;
    end
    @(posedge clk);
    t2 = $time;
    #1;
    bus.in_valid = 0;
    seen = 0;
    while (!bus.out_valid && seen < 50) begin
      @(posedge clk); #1;
      seen++;
    end
    p2 = bus.product;
    @(posedge clk); #1;
    bus.out_ready = 0;
    chk("b2b_p1", 32'(p1), 32'(ref_mul(2, 3)));
    chk("b2b_p2", 32'(p2), 32'(ref_mul(-4, 6)));
    chk("b2b_ii", 32'((t2 - t1) / 10), 32'd6);

    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (n % 50 == 0) x = 8'h80;
      if (n % 70 == 0) y = 8'h7f;
      do_op(x, y, int'($urandom_range(0, 2)), p, lat);
      chk("rand_product", 32'(p), 32'(ref_mul(x, y)));
      chk("rand_latency", 32'(lat), 32'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-4 Booth multiplier controller for the approximate-multiplication datapath. It accepts one signed operand pair over a valid/ready handshake, then walks the Booth triplets of the multiplier, one per clock. Each triplet passes through a single shared partial-product generator and correction-bit stage, and the weighted result is summed into an accumulator. The signed product is returned over a second valid/ready handshake, which lets area-constrained DNN processing elements reuse one Booth slice in place of a full parallel array.

## Interface
- WIDTH, 8, operand width in bits; must be even and ≥4; the product is 2*WIDTH bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair is valid.
- in_ready  out  1  block can accept an operand pair; high only in IDLE.
- a  in  WIDTH  signed multiplicand.
- b  in  WIDTH  signed multiplier (Booth-recoded).
- out_valid  out  1  product is valid; high only in DONE.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  signed accumulated product.
- busy  out  1  high in RUN.

## Operation
- FSM states are IDLE, RUN and DONE. Reset sets state=IDLE, product=0 and cnt=0. This gives in_ready=1, out_valid=0 and busy=0.
- IDLE: on in_valid&&in_ready, register a and b, clear the accumulator, set cnt=0 and move to RUN.
- RUN: in each cycle, triplet t = {b[2cnt+1], b[2cnt], b[2cnt-1]}, with b[-1]=0.
  - Digit mapping: 000 and 111 give 0; 001 and 010 give +a; 011 gives +2a; 100 gives −2a; 101 and 110 give −a.
  - Magnitude mag is 0, a or 2a, computed at WIDTH+1 bits.
  - The partial product is pp = t[2] ? ~mag : mag. pp is sign-extended to 2*WIDTH, and corr is added at bit 0 before the shift.
  - The accumulator updates as acc += (pp + corr) << 2cnt, in 2*WIDTH-bit arithmetic. Overflow wraps modulo 2^(2*WIDTH); for signed operands, the exact result never overflows.
  - cnt increments each cycle. After the update with cnt = WIDTH/2−1, move to DONE.
- DONE: product holds the accumulator value and out_valid=1. On out_valid&&out_ready, move to IDLE; product keeps its value.
- in_valid is ignored outside IDLE.
- out_ready is ignored outside DONE.
- rst in any state aborts the operation: the next state is IDLE, product=0, and no out_valid pulse is produced.

## Timing
- Operand handshake at edge E0. The block is in RUN for edges E1..E(WIDTH/2), and out_valid is high starting in the cycle after E(WIDTH/2).
- With WIDTH=8: 4 RUN cycles, and out_valid rises 4 cycles after the accepting edge.
- The minimum initiation interval is WIDTH/2+2 cycles with out_ready tied high (IDLE, 4×RUN, DONE for WIDTH=8).
- in_ready, out_valid and busy are decoded from the state register only, with no combinational path from in_valid or out_ready.
- product is registered.

## Configuration
- `APPROX_CORR_EN` defined:
  - corr = t[2] & (~(t[0]|t[1]) | ~(alsb|t[1]) | ~(alsb|t[0])), where alsb = a[0].
  - The product is approximate. Per-digit error is 0 or −1·4^cnt; it occurs for digits −a with odd a, and for digit 111.
- `APPROX_CORR_EN` undefined:
  - corr = t[2], giving exact two's-complement negation.
  - product == a*b for all inputs.

## Structure
- Package booth_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - the Booth digit typedef for the 3-bit triplet;
  - the localparam computing the triplet count as WIDTH/2 and the counter width as $clog2(WIDTH/2).
- Sub-module booth_pp_gen is combinational and takes triplet and a as inputs. It outputs the sign-extended pp and corr, and holds the `APPROX_CORR_EN` selection.
- The controller holds the FSM, the operand registers, cnt and the accumulator.

## Test plan
- Exact build, a=3 and b=3: out_valid rises 4 cycles after the accepting edge with product=9. Approx build, same operands: product=8.
- a=−128 and b=−128, in both builds: product=16384. Also a=127 and b=−128: product=−16256 in the exact build.
- out_ready held low for 3 cycles in DONE: product stays stable, out_valid=1, in_ready=0. A concurrent in_valid pulse is not accepted.
- rst asserted in RUN at cnt=2: in the next cycle state=IDLE, product=0, in_ready=1, and out_valid never pulses. A new pair 5×−7 then gives −35.
- Back-to-back pairs with out_ready=1 (2×3, then −4×6): products are 6 and then −24, with an initiation interval of 6 cycles.
- Random signed pairs (1000 or more) in the exact build match a*b. The approx build matches a reference model of the stated corr formula.
